// File: rtl/fir_inv_pkg.sv
// rtl/fir_inv_pkg.sv - shared types and constants for the inverse FIR
package fir_inv_pkg;

  // Largest supported filter length, counting the monic h0 tap
  localparam int MAX_TAPS = 8;

  // Default coefficients for taps 1..3
  localparam logic signed [31:0] H1_DEFAULT = 32'sd2;
  localparam logic signed [31:0] H2_DEFAULT = 32'sd3;
  localparam logic signed [31:0] H3_DEFAULT = 32'sd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_inv_mac.sv
// rtl/fir_inv_mac.sv - combinational multiply-subtract step, 32-bit wrap
module fir_inv_mac (
  input  logic [31:0] acc,
  input  logic [31:0] coeff,
  input  logic [31:0] sample,
  output logic [31:0] result
);

  // Low 32 bits of the product are identical for signed and unsigned operands
  assign result = acc - coeff * sample;

endmodule

// File: rtl/fir_inverse.sv
// rtl/fir_inverse.sv - recursive inverse of a monic FIR, one tap per cycle
module fir_inverse
  import fir_inv_pkg::*;
#(
  parameter int                NTAPS = 4,
  parameter logic signed [31:0] H1   = H1_DEFAULT,
  parameter logic signed [31:0] H2   = H2_DEFAULT,
  parameter logic signed [31:0] H3   = H3_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dataout,
  output logic        dout_valid,
  input  logic        dout_ready
);

  localparam int         NHIST = NTAPS - 1;
  localparam logic [2:0] KLAST = 3'(NTAPS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] acc;
  logic [2:0]  k;
  logic [31:0] hist [NHIST];
  logic [31:0] coeff;
  logic [31:0] sample;
  logic [31:0] mac_result;
  logic        last_step;

  assign last_step = (k == KLAST);

  // Coefficient for the tap currently being folded in; taps past 3 are zero
  always_comb begin
    coeff = '0;
    case (k)
      3'd1:    coeff = H1;
      3'd2:    coeff = H2;
      3'd3:    coeff = H3;
      default: coeff = '0;
    endcase
  end

  // Past recovered sample paired with tap k (hist[k-1])
  always_comb begin
    sample = '0;
    for (int i = 0; i < NHIST; i++) begin
      if (k == 3'(i + 1)) sample = hist[i];
    end
  end

  fir_inv_mac u_mac (
    .acc    (acc),
    .coeff  (coeff),
    .sample (sample),
    .result (mac_result)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; clr overrides every transition
  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state)
      IDLE: begin
        din_ready = !rst;
        if (din_valid) state_nxt = MAC;
      end
      MAC: begin
        if (last_step) state_nxt = OUT;
      end
      OUT: begin
        dout_valid = 1'b1;
        if (dout_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Accumulator, tap index, result register and history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      k       <= '0;
      dataout <= '0;
      for (int i = 0; i < NHIST; i++) hist[i] <= '0;
    end else if (clr) begin
      acc <= '0;
      k   <= '0;
      for (int i = 0; i < NHIST; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            acc <= din;
            k   <= 3'd1;
          end
        end
        MAC: begin
          acc <= mac_result;
          k   <= k + 3'd1;
          if (last_step) dataout <= mac_result;
        end
        OUT: begin
          // History only advances once the sample has actually left
          if (dout_ready) begin
            hist[0] <= dataout;
            for (int i = 1; i < NHIST; i++) hist[i] <= hist[i-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
